// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with bubble insertion and issue/bubble statistics
module id_ex_pipe_reg #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [63:0]      in_pc,
    input  logic [31:0]      in_instruction,
    input  logic [63:0]      in_rs1_data,
    input  logic [63:0]      in_rs2_data,
    input  logic [63:0]      in_imm,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_branch,
    input  logic             in_mem_read,
    input  logic             in_mem_to_reg,
    input  logic             in_mem_write,
    input  logic             in_alu_src,
    input  logic             in_reg_write,
    input  logic [1:0]       in_alu_op,
    output logic             out_valid,
    output logic [63:0]      out_pc,
    output logic [31:0]      out_instruction,
    output logic [63:0]      out_rs1_data,
    output logic [63:0]      out_rs2_data,
    output logic [63:0]      out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_branch,
    output logic             out_mem_read,
    output logic             out_mem_to_reg,
    output logic             out_mem_write,
    output logic             out_alu_src,
    output logic             out_reg_write,
    output logic [1:0]       out_alu_op,
    output logic [2:0]       out_funct3,
    output logic             out_funct7b5,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] bubble_count
);

    logic             r_valid;
    logic [63:0]      r_pc;
    logic [31:0]      r_instruction;
    logic [63:0]      r_rs1_data;
    logic [63:0]      r_rs2_data;
    logic [63:0]      r_imm;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic             r_branch;
    logic             r_mem_read;
    logic             r_mem_to_reg;
    logic             r_mem_write;
    logic             r_alu_src;
    logic             r_reg_write;
    logic [1:0]       r_alu_op;
    logic [2:0]       r_funct3;
    logic             r_funct7b5;
    logic [CNT_W-1:0] r_issue_count;
    logic [CNT_W-1:0] r_bubble_count;

    logic w_load;
    logic w_real;

    // Flush overrides stall; any load that is not a real instruction becomes a zeroed bubble.
    assign w_load = flush | ~stall;
    assign w_real = ~flush & in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid        <= 1'b0;
            r_pc           <= '0;
            r_instruction  <= '0;
            r_rs1_data     <= '0;
            r_rs2_data     <= '0;
            r_imm          <= '0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_rd           <= '0;
            r_branch       <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_mem_write    <= 1'b0;
            r_alu_src      <= 1'b0;
            r_reg_write    <= 1'b0;
            r_alu_op       <= '0;
            r_funct3       <= '0;
            r_funct7b5     <= 1'b0;
            r_issue_count  <= '0;
            r_bubble_count <= '0;
        end else if (w_load) begin
            r_valid        <= w_real;
            r_pc           <= w_real ? in_pc : '0;
            r_instruction  <= w_real ? in_instruction : '0;
            r_rs1_data     <= w_real ? in_rs1_data : '0;
            r_rs2_data     <= w_real ? in_rs2_data : '0;
            r_imm          <= w_real ? in_imm : '0;
            r_rs1          <= w_real ? in_rs1 : '0;
            r_rs2          <= w_real ? in_rs2 : '0;
            r_rd           <= w_real ? in_rd : '0;
            r_branch       <= w_real & in_branch;
            r_mem_read     <= w_real & in_mem_read;
            r_mem_to_reg   <= w_real & in_mem_to_reg;
            r_mem_write    <= w_real & in_mem_write;
            r_alu_src      <= w_real & in_alu_src;
            r_reg_write    <= w_real & in_reg_write;
            r_alu_op       <= w_real ? in_alu_op : '0;
            r_funct3       <= w_real ? in_instruction[14:12] : '0;
            r_funct7b5     <= w_real & in_instruction[30];
            // Saturating counters: exactly one of them is a candidate per load.
            if (w_real) begin
                if (r_issue_count != '1) r_issue_count <= r_issue_count + CNT_W'(1);
            end else begin
                if (r_bubble_count != '1) r_bubble_count <= r_bubble_count + CNT_W'(1);
            end
        end
    end

    assign out_valid       = r_valid;
    assign out_pc          = r_pc;
    assign out_instruction = r_instruction;
    assign out_rs1_data    = r_rs1_data;
    assign out_rs2_data    = r_rs2_data;
    assign out_imm         = r_imm;
    assign out_rs1         = r_rs1;
    assign out_rs2         = r_rs2;
    assign out_rd          = r_rd;
    assign out_branch      = r_branch;
    assign out_mem_read    = r_mem_read;
    assign out_mem_to_reg  = r_mem_to_reg;
    assign out_mem_write   = r_mem_write;
    assign out_alu_src     = r_alu_src;
    assign out_reg_write   = r_reg_write;
    assign out_alu_op      = r_alu_op;
    assign out_funct3      = r_funct3;
    assign out_funct7b5    = r_funct7b5;
    assign issue_count     = r_issue_count;
    assign bubble_count    = r_bubble_count;

endmodule
